ldtu_rx_decoder: RTL and testbench



---
 rtl/ldtu_rx_decoder_if.sv | 24 ++
 rtl/ldtu_rx_decoder.sv | 132 +++++++++++++
 tb/tb_ldtu_rx_decoder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ldtu_rx_decoder_if.sv
// Stream bundle for the LiTE-DTU receive decoder: 32-bit word input,
// 13-bit sample output and the per-word error pulses.
`timescale 1ns/1ps
interface ldtu_rx_decoder_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err_header;
  logic        err_count;
  logic        err_frame;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_header, err_count, err_frame
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_header, err_count, err_frame
  );
endinterface

// File: rtl/ldtu_rx_decoder.sv
// LiTE-DTU receive decoder: unpacks baseline/signal words into one 13-bit sample
// per cycle and checks trailer word counts and frame-number sequence.
`timescale 1ns/1ps
module ldtu_rx_decoder #(
  parameter int          Nbits_32  = 32,
  parameter int          Nbits_12  = 12,
  parameter logic [31:0] IDLE_WORD = 32'hEAAAAAAA,
  parameter int          CNT_BITS  = 8
) (
  input  logic              CLK,
  input  logic              rst_b,
  ldtu_rx_decoder_if.slave  bus
);

  localparam int SampleW = Nbits_12 + 1;

  typedef enum logic {EMPTY, UNPACK} state_e;

  state_e               state_q, state_d;
  logic [29:0]          shreg_q, shreg_d;
  logic [2:0]           remaining_q, remaining_d;
  logic                 is_sig_q, is_sig_d;
  logic [CNT_BITS-1:0]  wcnt_q, wcnt_d;
  logic [CNT_BITS-1:0]  fref_q, fref_d;
  logic                 fref_vld_q, fref_vld_d;
  logic                 err_header_q, err_header_d;
  logic                 err_count_q, err_count_d;
  logic                 err_frame_q, err_frame_d;

  logic [Nbits_32-1:0]  w;
  logic hdr_base5, hdr_basen, hdr_sig2, hdr_sig1, hdr_trl, hdr_idle;
  logic is_data, illegal, in_ready, accept, pop;

  assign w         = bus.in_data;
  assign hdr_base5 = (w[31:30] == 2'b01);
  assign hdr_basen = (w[31:30] == 2'b10) && (w[27:24] != 4'd0) && (w[27:24] <= 4'd4);
  assign hdr_sig2  = (w[31:26] == 6'b001010);
  assign hdr_sig1  = (w[31:26] == 6'b001011);
  assign hdr_trl   = (w[31:28] == 4'b1101);
  assign hdr_idle  = (w == IDLE_WORD);
  assign is_data   = hdr_base5 | hdr_basen | hdr_sig2 | hdr_sig1;
  assign illegal   = !(is_data | hdr_trl | hdr_idle);

  // A new word may enter on the edge that hands off the last sample of the current one.
  assign in_ready = rst_b && ((state_q == EMPTY) || (bus.out_ready && remaining_q == 3'd1));
  assign accept   = bus.in_valid && in_ready;
  assign pop      = (state_q == UNPACK) && bus.out_ready;

  always_comb begin
    // NOTE: every next-state signal gets its default first so no path can infer a latch.
    state_d      = state_q;
    shreg_d      = shreg_q;
    remaining_d  = remaining_q;
    is_sig_d     = is_sig_q;
    wcnt_d       = wcnt_q;
    fref_d       = fref_q;
    fref_vld_d   = fref_vld_q;
    err_header_d = 1'b0;
    err_count_d  = 1'b0;
    err_frame_d  = 1'b0;

    if (pop) begin
      shreg_d     = is_sig_q ? (shreg_q >> 13) : (shreg_q >> 6);
      remaining_d = remaining_q - 3'd1;
      if (remaining_q == 3'd1) state_d = EMPTY;
    end

    if (accept) begin
      if (is_data) begin
        state_d  = UNPACK;
        is_sig_d = hdr_sig2 | hdr_sig1;
        wcnt_d   = (wcnt_q == '1) ? wcnt_q : wcnt_q + CNT_BITS'(1);
        if (hdr_base5) begin
          shreg_d     = w[29:0];
          remaining_d = 3'd5;
        end else if (hdr_basen) begin
          shreg_d     = {6'b0, w[23:0]};
          remaining_d = 3'(w[27:24]);
        end else if (hdr_sig2) begin
          shreg_d     = {4'b0, w[25:0]};
          remaining_d = 3'd2;
        end else begin
          shreg_d     = {17'b0, w[12:0]};
          remaining_d = 3'd1;
        end
      end else if (hdr_trl) begin
        err_count_d = (CNT_BITS'(w[19:12]) != wcnt_q);
        wcnt_d      = '0;
        err_frame_d = fref_vld_q && (CNT_BITS'(w[27:20]) != fref_q + CNT_BITS'(1));
        fref_d      = CNT_BITS'(w[27:20]);
        fref_vld_d  = 1'b1;
      end else if (illegal) begin
        err_header_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_b) begin
      state_q      <= EMPTY;
      shreg_q      <= '0;
      remaining_q  <= '0;
      is_sig_q     <= 1'b0;
      wcnt_q       <= '0;
      fref_q       <= '0;
      fref_vld_q   <= 1'b0;
      err_header_q <= 1'b0;
      err_count_q  <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      remaining_q  <= remaining_d;
      is_sig_q     <= is_sig_d;
      wcnt_q       <= wcnt_d;
      fref_q       <= fref_d;
      fref_vld_q   <= fref_vld_d;
      err_header_q <= err_header_d;
      err_count_q  <= err_count_d;
      err_frame_q  <= err_frame_d;
    end
  end

  // Baseline samples carry no gain bit; signal samples are taken whole.
  assign bus.out_data   = is_sig_q ? SampleW'(shreg_q[12:0]) : SampleW'(shreg_q[5:0]);
  assign bus.out_valid  = (state_q == UNPACK);
  assign bus.in_ready   = in_ready;
  assign bus.err_header = err_header_q;
  assign bus.err_count  = err_count_q;
  assign bus.err_frame  = err_frame_q;

endmodule

// File: tb/tb_ldtu_rx_decoder.sv
// Self-checking bench for ldtu_rx_decoder: vector table of single words plus
// hand-written sequences for back-to-back, backpressure, trailers and reset.
`timescale 1ns/1ps
module tb_ldtu_rx_decoder;

  logic CLK = 1'b0;
  logic rst_b = 1'b0;

  ldtu_rx_decoder_if bus();

  ldtu_rx_decoder dut (
    .CLK   (CLK),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    int          n;
    logic [12:0] s [5];
    int          hdr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_hdr = 0, n_cnt = 0, n_frm = 0;
  logic [12:0] sb [$];
  int          hs_cyc [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: sampled mid-low-phase, after the driver has settled its inputs.
  always @(negedge CLK) begin
    #2;
    if (rst_b) begin
      if (bus.err_header) n_hdr++;
      if (bus.err_count)  n_cnt++;
      if (bus.err_frame)  n_frm++;
      if (bus.out_valid && bus.out_ready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_sample actual=%h required=no_output", bus.out_data);
        end else begin
          check("sample", 32'(bus.out_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic send(input logic [31:0] w);
    bit ok = 1'b0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      #1;
      ok = bus.in_ready;
      @(posedge CLK);
      @(negedge CLK);
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted word=%h", w);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
    check("drain_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic push5(input logic [12:0] a, b, c, d, e);
    sb.push_back(a); sb.push_back(b); sb.push_back(c); sb.push_back(d); sb.push_back(e);
  endtask

  task automatic trailer(input string name, input logic [31:0] w, input int exp_cnt, input int exp_frm);
    int c0, f0, h0;
    c0 = n_cnt; f0 = n_frm; h0 = n_hdr;
    send(w);
    repeat (3) @(negedge CLK);
    check({name, "_err_count"},  32'(n_cnt - c0), 32'(exp_cnt));
    check({name, "_err_frame"},  32'(n_frm - f0), 32'(exp_frm));
    check({name, "_err_header"}, 32'(n_hdr - h0), 32'd0);
  endtask

  initial begin
    vec_t vecs [9];
    int   h0, c0, span;
    logic [12:0] held;

    // Signal words use header 001010 (two samples) and 001011 (one sample).
    vecs[0] = '{32'h45103081, 5, '{13'h0001, 13'h0002, 13'h0003, 13'h0004, 13'h0005}, 0};
    vecs[1] = '{32'h28247ABC, 2, '{13'h1ABC, 13'h0123, 13'h0, 13'h0, 13'h0}, 0};
    vecs[2] = '{32'h2C001FFF, 1, '{13'h1FFF, 13'h0, 13'h0, 13'h0, 13'h0}, 0};
    vecs[3] = '{32'h8302A03F, 3, '{13'h003F, 13'h0000, 13'h002A, 13'h0, 13'h0}, 0};
    vecs[4] = '{32'h84FFFFFF, 4, '{13'h003F, 13'h003F, 13'h003F, 13'h003F, 13'h0}, 0};
    vecs[5] = '{32'hEAAAAAAA, 0, '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0}, 0};
    vecs[6] = '{32'hFFFF0000, 0, '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0}, 1};
    vecs[7] = '{32'h80000000, 0, '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0}, 1};
    vecs[8] = '{32'h85000000, 0, '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0}, 1};

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_b         = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_data",   32'(bus.out_data),   32'd0);
    check("rst_in_ready",   32'(bus.in_ready),   32'd0);
    check("rst_err_header", 32'(bus.err_header), 32'd0);
    check("rst_err_count",  32'(bus.err_count),  32'd0);
    check("rst_err_frame",  32'(bus.err_frame),  32'd0);
    @(negedge CLK);
    rst_b = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 9; i++) begin
      h0 = n_hdr;
      c0 = n_cnt;
      for (int k = 0; k < vecs[i].n; k++) sb.push_back(vecs[i].s[k]);
      send(vecs[i].word);
      drain();
      check($sformatf("vec%0d_err_header", i), 32'(n_hdr - h0), 32'(vecs[i].hdr));
      check($sformatf("vec%0d_err_count", i),  32'(n_cnt - c0), 32'd0);
    end
    // Five legal data words so far; idle and illegal words must not count.
    trailer("tr_first", 32'hD0005000, 0, 0);

    // Back-to-back words: seven samples on seven consecutive cycles.
    hs_cyc.delete();
    push5(13'h0001, 13'h0002, 13'h0003, 13'h0004, 13'h0005);
    sb.push_back(13'h1ABC);
    sb.push_back(13'h0123);
    send(32'h45103081);
    send(32'h28247ABC);
    drain();
    check("b2b_count", 32'(hs_cyc.size()), 32'd7);
    span = (hs_cyc.size() == 7) ? hs_cyc[6] - hs_cyc[0] : -1;
    check("b2b_span", 32'(span), 32'd6);

    // Backpressure: stall three cycles on the second sample.
    push5(13'h0001, 13'h0002, 13'h0003, 13'h0004, 13'h0005);
    send(32'h45103081);
    @(negedge CLK);
    bus.out_ready = 1'b0;
    #1;
    held = bus.out_data;
    check("bp_held_value", 32'(held), 32'h0002);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      check("bp_hold", 32'(bus.out_data), 32'(held));
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    drain();

    // Trailer checks from a clean reset.
    rst_b = 1'b0;
    @(negedge CLK);
    rst_b = 1'b1;
    @(negedge CLK);
    sb.push_back(13'h0001);
    sb.push_back(13'h0002);
    sb.push_back(13'h0003);
    send(32'h2C000001);
    send(32'h2C000002);
    send(32'h2C000003);
    drain();
    trailer("tr_count_bad", 32'hD0102000, 1, 0);
    trailer("tr_frame_bad", 32'hD0300000, 0, 1);
    trailer("tr_frame_ok",  32'hD0400000, 0, 0);

    // Reset in the middle of unpacking discards the rest of the word.
    push5(13'h0001, 13'h0002, 13'h0003, 13'h0004, 13'h0005);
    send(32'h45103081);
    @(negedge CLK);
    @(negedge CLK);
    rst_b = 1'b0;
    sb.delete();
    @(negedge CLK);
    rst_b = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (5) @(negedge CLK);
    sb.push_back(13'h1ABC);
    sb.push_back(13'h0123);
    send(32'h28247ABC);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
